regfile_write_scheduler: RTL and testbench
==========================================

Name: regfile_write_scheduler

Overview:
- Schedules the single register-file write port between pipeline writeback and the multi-cycle multiply/divide unit (MDU).
- Keeps a busy scoreboard for registers with an MDU result still pending, and raises the decode stall on RAW/WAW hazards against those registers.
- Sits between the WB stage, the MDU result interface and the register file write port (write_en/rd_addr/rd_data).

Parameters:
- XLEN, 32, data width of write data and MDU results.
- STARVE_LIMIT, 4, consecutive cycles a held MDU result may lose to pipeline writeback before it is force-granted (range 1..15).

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- dec_rs1_addr  input  5  decode-stage source 1 address.
- dec_rs2_addr  input  5  decode-stage source 2 address.
- dec_rd_addr  input  5  decode-stage destination address.
- dec_rd_valid  input  1  decode instruction writes rd.
- mdu_issue  input  1  MDU op leaves decode this cycle; only asserted when stall=0.
- mdu_issue_rd  input  5  destination of the issued MDU op.
- mdu_res_valid  input  1  MDU result available.
- mdu_res_rd  input  5  MDU result destination.
- mdu_res_data  input  XLEN  MDU result value.
- mdu_res_ready  output  1  result accepted when valid&&ready.
- wb_en  input  1  WB stage requests a write.
- wb_addr  input  5  WB destination.
- wb_data  input  XLEN  WB value.
- wb_grant  output  1  WB write performed this cycle; wb_en&&!wb_grant means WB must hold its contents.
- rf_write_en  output  1  to register file write_en.
- rf_rd_addr  output  5  to register file rd_addr.
- rf_rd_data  output  XLEN  to register file rd_data.
- stall  output  1  freeze fetch/decode.

Behaviour:
- State:
  - busy[31:1], one scoreboard bit per register; x0 is never busy.
  - hold_valid, hold_rd, hold_data: one-entry buffer for a held MDU result.
  - starve_cnt, 4 bits.
- Reset: all state cleared. While reset is high, every output is 0 (mdu_res_ready, wb_grant, rf_write_en, rf_rd_addr, rf_rd_data, stall). A reset mid-operation discards the held result and all busy bits.
- Scoreboard set:
  - mdu_issue && mdu_issue_rd!=0 sets busy[mdu_issue_rd] at the clock edge.
- Scoreboard clear:
  - The busy bit of the held result is cleared at the same edge the held result is written.
  - If the same register is set and cleared in one cycle, set wins. This cannot occur legally because of WAW stalling, but it is the required behaviour.
- MDU acceptance:
  - mdu_res_ready = !hold_valid.
  - On valid&&ready the result is captured into the hold buffer.
  - Minimum latency from acceptance to register-file write is 1 cycle.
  - mdu_res_rd==0 is accepted and dropped: hold_valid stays 0 and no write occurs.
- Write-port arbitration (combinational from state and inputs):
  - drain = hold_valid && (!wb_en || wb_addr==0 || starve_cnt==STARVE_LIMIT).
  - wb_grant = wb_en && !drain.
  - When drain: rf_write_en=1 and addr/data come from the hold buffer.
  - Else when wb_grant && wb_addr!=0: rf_write_en=1 and addr/data come from wb.
  - Otherwise rf_write_en=0.
  - A granted wb write to x0 produces no rf write.
- Starvation counter:
  - Increments when hold_valid && !drain.
  - Resets to 0 on drain or whenever hold_valid=0.
  - Never exceeds STARVE_LIMIT.
- Stall (combinational) is the OR of:
  - RAW: dec_rs1_addr!=0 && busy[dec_rs1_addr], or the same test on rs2.
  - WAW: dec_rd_valid && dec_rd_addr!=0 && busy[dec_rd_addr].
  - Busy bits are cleared only at the write edge, so a decode read of the register in the drain cycle still stalls. The synchronous-read register file then returns the new value the following cycle.
- wb_grant does not depend on stall. WB hazards against non-busy registers belong to the forwarding logic, not to this block.

Test Plan:
- Issue then read:
  - Stimulus: mdu_issue rd=5; decode rs1=5 for the next 10 cycles; mdu_res_valid rd=5 data=0xDEADBEEF at cycle 6; wb_en=0.
  - Required: stall=1 from cycle 1 through the drain cycle (cycle 7, rf_write_en=1 addr=5 data=0xDEADBEEF); stall=0 from cycle 8.
- WB priority and starvation, STARVE_LIMIT=4:
  - Stimulus: hold loaded with rd=3; wb_en=1 addr=7 continuously.
  - Required: wb_grant=1 for 4 cycles; 5th cycle wb_grant=0 and the rf write is rd=3; next cycle wb_grant=1 again with the same wb data written.
- Idle-slot drain:
  - Stimulus: hold loaded with rd=9; wb_en=1 addr=0.
  - Required: drain the same cycle; wb_grant=0; rf write rd=9.
- Back-pressure:
  - Stimulus: two MDU results (rd=4, rd=6) back-to-back; wb_en=1 addr=2 continuously.
  - Required: mdu_res_ready=0 while rd=4 is held; rd=4 written after 4 losses; rd=6 accepted the cycle after its drain.
- WAW and x0:
  - Stimulus: busy[8] set; decode dec_rd_valid with rd=8.
  - Required: stall=1.
  - Stimulus: mdu_issue_rd=0.
  - Required: no busy bit set and no later stall.
- Reset mid-operation:
  - Stimulus: reset asserted while hold_valid=1 and busy[12]=1.
  - Required: all outputs 0 during reset; after reset rs1=12 gives stall=0, mdu_res_ready=1 and no write for the discarded result.

Source files
------------

// File: rtl/regfile_write_scheduler.sv
// regfile_write_scheduler
//   Shares the single register-file write port between pipeline writeback
//   and the multi-cycle MDU. Keeps a busy scoreboard for registers whose MDU
//   result is still outstanding, and stalls decode on RAW/WAW hazards
//   against them.
//
// Ports
//   clk, reset                      clock, synchronous active-high reset
//   dec_rs1_addr, dec_rs2_addr      decode-stage source addresses
//   dec_rd_addr, dec_rd_valid       decode-stage destination and its valid
//   mdu_issue, mdu_issue_rd         MDU op leaving decode and its rd
//   mdu_res_valid/rd/data, mdu_res_ready
//                                   MDU result handshake
//   wb_en, wb_addr, wb_data         writeback write request
//   wb_grant                        writeback write performed this cycle
//   rf_write_en, rf_rd_addr, rf_rd_data
//                                   register-file write port
//   stall                           freeze fetch/decode
module regfile_write_scheduler #(
  parameter int XLEN         = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [4:0]      dec_rs1_addr,
  input  logic [4:0]      dec_rs2_addr,
  input  logic [4:0]      dec_rd_addr,
  input  logic            dec_rd_valid,
  input  logic            mdu_issue,
  input  logic [4:0]      mdu_issue_rd,
  input  logic            mdu_res_valid,
  input  logic [4:0]      mdu_res_rd,
  input  logic [XLEN-1:0] mdu_res_data,
  output logic            mdu_res_ready,
  input  logic            wb_en,
  input  logic [4:0]      wb_addr,
  input  logic [XLEN-1:0] wb_data,
  output logic            wb_grant,
  output logic            rf_write_en,
  output logic [4:0]      rf_rd_addr,
  output logic [XLEN-1:0] rf_rd_data,
  output logic            stall
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  // Scoreboard: bit 0 is never set, so x0 can never be busy.
  logic [31:0]     busy;
  logic [31:0]     busy_next;
  logic            hold_valid;
  logic [4:0]      hold_rd;
  logic [XLEN-1:0] hold_data;
  logic [3:0]      starve_cnt;

  logic drain;
  logic accept;
  logic haz_rs1;
  logic haz_rs2;
  logic haz_rd;

  // Write-port arbitration, hazard detection and output muxing
  always_comb begin
    // The held result wins when WB is idle, targets x0 (no real write), or
    // the held result has lost STARVE_LIMIT times in a row.
    drain   = hold_valid && (!wb_en || wb_addr == 5'd0 || starve_cnt == LIMIT);
    accept  = mdu_res_valid && !hold_valid && (mdu_res_rd != 5'd0);
    haz_rs1 = (dec_rs1_addr != 5'd0) && busy[dec_rs1_addr];
    haz_rs2 = (dec_rs2_addr != 5'd0) && busy[dec_rs2_addr];
    haz_rd  = dec_rd_valid && (dec_rd_addr != 5'd0) && busy[dec_rd_addr];

    mdu_res_ready = 1'b0;
    wb_grant      = 1'b0;
    rf_write_en   = 1'b0;
    rf_rd_addr    = 5'd0;
    rf_rd_data    = '0;
    stall         = 1'b0;

    if (reset) begin
      mdu_res_ready = 1'b0;
    end else begin
      mdu_res_ready = !hold_valid;
      wb_grant      = wb_en && !drain;
      stall         = haz_rs1 || haz_rs2 || haz_rd;
      if (drain) begin
        rf_write_en = 1'b1;
        rf_rd_addr  = hold_rd;
        rf_rd_data  = hold_data;
      end else if (wb_en && (wb_addr != 5'd0)) begin
        rf_write_en = 1'b1;
        rf_rd_addr  = wb_addr;
        rf_rd_data  = wb_data;
      end else begin
        rf_write_en = 1'b0;
      end
    end
  end

  // Next scoreboard value: clear on drain first so a same-cycle set wins
  always_comb begin
    busy_next = busy;
    if (drain) begin
      busy_next[hold_rd] = 1'b0;
    end else begin
      busy_next = busy;
    end
    if (mdu_issue && (mdu_issue_rd != 5'd0)) begin
      busy_next[mdu_issue_rd] = 1'b1;
    end else begin
      busy_next[0] = 1'b0;
    end
    busy_next[0] = 1'b0;
  end

  // Scoreboard, hold buffer and starvation counter
  always_ff @(posedge clk) begin
    if (reset) begin
      busy       <= 32'd0;
      hold_valid <= 1'b0;
      hold_rd    <= 5'd0;
      hold_data  <= '0;
      starve_cnt <= 4'd0;
    end else begin
      busy <= busy_next;
      // Acceptance requires an empty buffer, so drain and accept never collide.
      if (drain) begin
        hold_valid <= 1'b0;
      end else if (accept) begin
        hold_valid <= 1'b1;
        hold_rd    <= mdu_res_rd;
        hold_data  <= mdu_res_data;
      end
      // Reaching LIMIT forces a drain, which returns the count to zero.
      if (hold_valid && !drain) begin
        starve_cnt <= starve_cnt + 4'd1;
      end else begin
        starve_cnt <= 4'd0;
      end
    end
  end

endmodule

// File: tb/tb_regfile_write_scheduler.sv
module tb_regfile_write_scheduler;

  localparam int LIM = 4;

  typedef struct {
    logic        rst;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        rdv;
    logic [4:0]  rd;
    logic        iss;
    logic [4:0]  iss_rd;
    logic        mv;
    logic [4:0]  mrd;
    logic [31:0] mdata;
    logic        wbe;
    logic [4:0]  wba;
    logic [31:0] wbd;
    logic        e_ready;
    logic        e_grant;
    logic        e_we;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    logic        e_stall;
  } vec_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } hold_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  dec_rs1_addr, dec_rs2_addr, dec_rd_addr;
  logic        dec_rd_valid;
  logic        mdu_issue;
  logic [4:0]  mdu_issue_rd;
  logic        mdu_res_valid;
  logic [4:0]  mdu_res_rd;
  logic [31:0] mdu_res_data;
  logic        mdu_res_ready;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        wb_grant;
  logic        rf_write_en;
  logic [4:0]  rf_rd_addr;
  logic [31:0] rf_rd_data;
  logic        stall;

  int total = 0;
  int bad   = 0;
  int step  = 0;

  // Reference model state: scoreboard as a flag array, hold buffer as a queue
  bit    m_busy[32];
  hold_t m_hold[$];
  int    m_cnt;

  regfile_write_scheduler #(.XLEN(32), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .reset(reset),
    .dec_rs1_addr(dec_rs1_addr), .dec_rs2_addr(dec_rs2_addr),
    .dec_rd_addr(dec_rd_addr), .dec_rd_valid(dec_rd_valid),
    .mdu_issue(mdu_issue), .mdu_issue_rd(mdu_issue_rd),
    .mdu_res_valid(mdu_res_valid), .mdu_res_rd(mdu_res_rd),
    .mdu_res_data(mdu_res_data), .mdu_res_ready(mdu_res_ready),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .wb_grant(wb_grant),
    .rf_write_en(rf_write_en), .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data),
    .stall(stall)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(
    input logic rst, input logic [4:0] rs1, input logic [4:0] rs2,
    input logic rdv, input logic [4:0] rd, input logic iss, input logic [4:0] iss_rd,
    input logic mv, input logic [4:0] mrd, input logic [31:0] mdata,
    input logic wbe, input logic [4:0] wba, input logic [31:0] wbd,
    input logic e_ready, input logic e_grant, input logic e_we,
    input logic [4:0] e_addr, input logic [31:0] e_data, input logic e_stall);
    vec_t v;
    v.rst = rst; v.rs1 = rs1; v.rs2 = rs2; v.rdv = rdv; v.rd = rd;
    v.iss = iss; v.iss_rd = iss_rd; v.mv = mv; v.mrd = mrd; v.mdata = mdata;
    v.wbe = wbe; v.wba = wba; v.wbd = wbd;
    v.e_ready = e_ready; v.e_grant = e_grant; v.e_we = e_we;
    v.e_addr = e_addr; v.e_data = e_data; v.e_stall = e_stall;
    return v;
  endfunction

  function automatic bit m_drain(input vec_t v);
    return (m_hold.size() != 0) && (!v.wbe || v.wba == 5'd0 || m_cnt == LIM);
  endfunction

  // Expected outputs for this cycle's inputs, from the model's current state
  function automatic vec_t model_eval(input vec_t v);
    vec_t r = v;
    bit   dr;
    r.e_ready = 1'b0; r.e_grant = 1'b0; r.e_we = 1'b0;
    r.e_addr = 5'd0; r.e_data = 32'd0; r.e_stall = 1'b0;
    if (!v.rst) begin
      dr = m_drain(v);
      r.e_ready = (m_hold.size() == 0);
      r.e_grant = v.wbe && !dr;
      if (dr) begin
        r.e_we = 1'b1; r.e_addr = m_hold[0].rd; r.e_data = m_hold[0].data;
      end else if (r.e_grant && v.wba != 5'd0) begin
        r.e_we = 1'b1; r.e_addr = v.wba; r.e_data = v.wbd;
      end
      r.e_stall = (v.rs1 != 5'd0 && m_busy[v.rs1]) || (v.rs2 != 5'd0 && m_busy[v.rs2])
               || (v.rdv && v.rd != 5'd0 && m_busy[v.rd]);
    end
    return r;
  endfunction

  task automatic model_advance(input vec_t v);
    bit had, dr;
    if (v.rst) begin
      foreach (m_busy[i]) m_busy[i] = 1'b0;
      m_hold.delete();
      m_cnt = 0;
    end else begin
      had = (m_hold.size() != 0);
      dr  = m_drain(v);
      if (dr) m_busy[m_hold[0].rd] = 1'b0;
      if (v.iss && v.iss_rd != 5'd0) m_busy[v.iss_rd] = 1'b1;
      m_cnt = (had && !dr) ? m_cnt + 1 : 0;
      if (dr) void'(m_hold.pop_front());
      else if (!had && v.mv && v.mrd != 5'd0) m_hold.push_back('{rd: v.mrd, data: v.mdata});
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL step %0d %s: got %0h expected %0h", step, name, act, exp);
    end
  endtask

  // Drive one cycle, check before the edge, then advance the model at the edge
  task automatic run(input vec_t v, input bit use_model);
    vec_t e;
    reset = v.rst; dec_rs1_addr = v.rs1; dec_rs2_addr = v.rs2;
    dec_rd_valid = v.rdv; dec_rd_addr = v.rd; mdu_issue = v.iss; mdu_issue_rd = v.iss_rd;
    mdu_res_valid = v.mv; mdu_res_rd = v.mrd; mdu_res_data = v.mdata;
    wb_en = v.wbe; wb_addr = v.wba; wb_data = v.wbd;
    @(negedge clk);
    e = use_model ? model_eval(v) : v;
    chk("mdu_res_ready", 32'(mdu_res_ready), 32'(e.e_ready));
    chk("wb_grant", 32'(wb_grant), 32'(e.e_grant));
    chk("rf_write_en", 32'(rf_write_en), 32'(e.e_we));
    chk("stall", 32'(stall), 32'(e.e_stall));
    if (e.e_we || v.rst) begin
      chk("rf_rd_addr", 32'(rf_rd_addr), 32'(e.e_addr));
      chk("rf_rd_data", rf_rd_data, e.e_data);
    end
    @(posedge clk);
    model_advance(v);
    #1;
    step++;
  endtask

  vec_t dir[$];
  vec_t rv, ev;

  initial begin
    // Reset with busy inputs: every output must read zero
    dir.push_back(mk(1, 5, 5, 1, 5, 1, 5, 1, 5, 32'h1234, 1, 7, 32'h77, 0, 0, 0, 0, 32'h0, 0));
    dir.push_back(mk(1, 5, 5, 1, 5, 1, 5, 1, 5, 32'h1234, 1, 7, 32'h77, 0, 0, 0, 0, 32'h0, 0));
    // Issue rd=5, read it for 10 cycles, result arrives in cycle 6
    dir.push_back(mk(0, 0, 0, 0, 0, 1, 5, 0, 0, 32'h0, 0, 0, 32'h0, 1, 0, 0, 0, 32'h0, 0));
    for (int i = 0; i < 5; i++)
      dir.push_back(mk(0, 5, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 32'h0, 1, 0, 0, 0, 32'h0, 1));
    dir.push_back(mk(0, 5, 0, 0, 0, 0, 0, 1, 5, 32'hDEADBEEF, 0, 0, 32'h0, 1, 0, 0, 0, 32'h0, 1));
    dir.push_back(mk(0, 5, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 1, 5, 32'hDEADBEEF, 1));
    dir.push_back(mk(0, 5, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 32'h0, 1, 0, 0, 0, 32'h0, 0));
    dir.push_back(mk(0, 5, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 32'h0, 1, 0, 0, 0, 32'h0, 0));
    // WB priority and starvation: hold rd=3, WB writes x7 continuously
    dir.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 3, 32'h33, 1, 7, 32'h77, 1, 1, 1, 7, 32'h77, 0));
    for (int i = 0; i < 4; i++)
      dir.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 1, 7, 32'h77, 0, 1, 1, 7, 32'h77, 0));
    dir.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 1, 7, 32'h77, 0, 0, 1, 3, 32'h33, 0));
    dir.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 1, 7, 32'h77, 1, 1, 1, 7, 32'h77, 0));
    // Idle-slot drain: WB to x0 yields the port immediately
    dir.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 9, 32'h99, 1, 0, 32'h55, 1, 1, 0, 0, 32'h0, 0));
    dir.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 1, 0, 32'h55, 0, 0, 1, 9, 32'h99, 0));
    dir.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 32'h0, 1, 0, 0, 0, 32'h0, 0));
    // Back-pressure: rd=4 then rd=6 with WB writing x2 continuously
    dir.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 4, 32'h44, 1, 2, 32'h22, 1, 1, 1, 2, 32'h22, 0));
    for (int i = 0; i < 4; i++)
      dir.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 6, 32'h66, 1, 2, 32'h22, 0, 1, 1, 2, 32'h22, 0));
    dir.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 6, 32'h66, 1, 2, 32'h22, 0, 0, 1, 4, 32'h44, 0));
    dir.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 6, 32'h66, 1, 2, 32'h22, 1, 1, 1, 2, 32'h22, 0));
    dir.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 1, 2, 32'h22, 0, 1, 1, 2, 32'h22, 0));
    dir.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 1, 6, 32'h66, 0));
    // WAW on x8, RAW on rs2, and issue to x0 never marks anything busy
    dir.push_back(mk(0, 0, 0, 0, 0, 1, 8, 0, 0, 32'h0, 0, 0, 32'h0, 1, 0, 0, 0, 32'h0, 0));
    dir.push_back(mk(0, 0, 0, 1, 8, 0, 0, 0, 0, 32'h0, 0, 0, 32'h0, 1, 0, 0, 0, 32'h0, 1));
    dir.push_back(mk(0, 0, 8, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 32'h0, 1, 0, 0, 0, 32'h0, 1));
    dir.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 32'h0, 0, 0, 32'h0, 1, 0, 0, 0, 32'h0, 0));
    dir.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 32'h0, 0, 0, 32'h0, 1, 0, 0, 0, 32'h0, 0));
    // Reset mid-operation with rd=12 held and busy
    dir.push_back(mk(0, 0, 0, 0, 0, 1, 12, 1, 12, 32'hC, 1, 7, 32'h77, 1, 1, 1, 7, 32'h77, 0));
    dir.push_back(mk(1, 12, 0, 0, 0, 0, 0, 1, 5, 32'h5, 1, 7, 32'h77, 0, 0, 0, 0, 32'h0, 0));
    dir.push_back(mk(1, 12, 0, 0, 0, 0, 0, 1, 5, 32'h5, 1, 7, 32'h77, 0, 0, 0, 0, 32'h0, 0));
    dir.push_back(mk(0, 12, 8, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 32'h0, 1, 0, 0, 0, 32'h0, 0));
    dir.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 32'h0, 1, 0, 0, 0, 32'h0, 0));

    reset = 1'b1;
    @(posedge clk);
    #1;
    foreach (dir[i]) run(dir[i], 1'b0);

    // Randomized traffic against the reference model
    run(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 0, 0, 32'h0, 0), 1'b1);
    for (int n = 0; n < 800; n++) begin
      rv = mk(($urandom_range(0, 63) == 0), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
              1'($urandom), 5'($urandom_range(0, 7)), 0, 0,
              1'($urandom), 5'($urandom_range(0, 7)), $urandom,
              ($urandom_range(0, 9) < 7), 5'($urandom_range(0, 7)), $urandom,
              0, 0, 0, 0, 32'h0, 0);
      ev = model_eval(rv);
      // An MDU op may only leave decode when the decode stage is not stalled
      if (!rv.rst && rv.rdv && !ev.e_stall && $urandom_range(0, 2) == 0) begin
        rv.iss = 1'b1;
        rv.iss_rd = rv.rd;
      end
      run(rv, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
